// File: rtl/pipelined_add_sub.sv
// pipelined_add_sub: parametrised add/subtract with the carry chain split
// into STAGES equal chunks, one chunk resolved per register stage.
// valid/ready flow control with a single global advance (stall) signal.
module pipelined_add_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);
   localparam int C    = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             carry0;

   // The whole pipe moves unless a finished result is being refused.
   assign advance  = !(out_valid && !out_ready);
   assign in_ready = rst || advance;

   // Subtraction is a + ~b + ~borrow_in.
   assign b_eff  = sub ? ~b : b;
   assign carry0 = cin ^ sub;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic [WIDTH-1:0] s_next;
      logic             c_in;
      logic             z_in;
      logic             v_in;
      logic [C:0]       chunk;
      logic [WIDTH-1:0] q_s;
      logic             q_c;
      logic             q_z;
      logic             q_v;

      if (k == 0) begin : g_src
         assign a_in = a;
         assign b_in = b_eff;
         assign s_in = '0;
         assign c_in = carry0;
         assign z_in = 1'b1;
         assign v_in = in_valid;
      end else begin : g_src
         assign a_in = g_stage[k-1].g_fwd.q_a;
         assign b_in = g_stage[k-1].g_fwd.q_b;
         assign s_in = g_stage[k-1].q_s;
         assign c_in = g_stage[k-1].q_c;
         assign z_in = g_stage[k-1].q_z;
         assign v_in = g_stage[k-1].q_v;
      end

      assign chunk = {1'b0, a_in[k*C +: C]} + {1'b0, b_in[k*C +: C]} + {{C{1'b0}}, c_in};

      // Merge this stage's sum chunk into the partial result carried forward.
      always_comb begin
         s_next           = s_in;
         s_next[k*C +: C] = chunk[C-1:0];
      end

      // Stage register: partial sum, chunk carry, running zero flag, valid.
      always_ff @(posedge clk) begin
         if (rst) begin
            q_v <= 1'b0;
            q_s <= '0;
            q_c <= 1'b0;
            q_z <= 1'b0;
         end else if (advance) begin
            q_v <= v_in;
            q_s <= s_next;
            q_c <= chunk[C];
            q_z <= z_in && (chunk[C-1:0] == '0);
         end
      end

      if (k < LAST) begin : g_fwd
         logic [WIDTH-1:0] q_a;
         logic [WIDTH-1:0] q_b;

         // Operands travel with their beat so upper chunks can be added later.
         always_ff @(posedge clk) begin
            if (rst) begin
               q_a <= '0;
               q_b <= '0;
            end else if (advance) begin
               q_a <= a_in;
               q_b <= b_in;
            end
         end
      end else begin : g_last
         logic q_ovf;
         logic unused_ops;

         // Lower operand chunks are already consumed; only the MSBs matter here.
         assign unused_ops = ^{a_in, b_in};

         // Signed overflow: like-signed operands giving a differently-signed sum.
         always_ff @(posedge clk) begin
            if (rst) begin
               q_ovf <= 1'b0;
            end else if (advance) begin
               q_ovf <= (a_in[WIDTH-1] == b_in[WIDTH-1]) && (s_next[WIDTH-1] != a_in[WIDTH-1]);
            end
         end
      end
   end

   assign out_valid = g_stage[LAST].q_v;
   assign sum       = g_stage[LAST].q_s;
   assign cout      = g_stage[LAST].q_c;
   assign zero      = g_stage[LAST].q_z;
   assign ovf       = g_stage[LAST].g_last.q_ovf;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: one 32-bit/4-stage instance plus 8-bit
// instances with 1, 2 and 8 stages, all checked against an arithmetic model.
module tb_pipelined_add_sub;
   localparam int NDUT = 4;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
   } res_t;

   typedef struct {
      res_t r;
      int   t;
      bit   strict;
   } exp_e;

   logic        clk;
   logic        rst;
   logic [31:0] a_d   [NDUT];
   logic [31:0] b_d   [NDUT];
   logic        iv_d  [NDUT];
   logic        cin_d [NDUT];
   logic        sub_d [NDUT];
   logic        or_d  [NDUT];
   int          cyc;
   bit          strict_lat;
   int          checks;
   int          failures;

   function automatic int cfg_w(input int g);
      return (g == 0) ? 32 : 8;
   endfunction

   function automatic int cfg_s(input int g);
      case (g)
         0: return 4;
         1: return 1;
         2: return 2;
         default: return 8;
      endcase
   endfunction

   // True integer arithmetic: unsigned result for sum/cout, signed for ovf.
   function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic cin, input logic sub);
      longint unsigned m    = (64'd1 << w) - 1;
      longint unsigned ua   = {32'd0, a} & m;
      longint unsigned ub   = {32'd0, b} & m;
      longint unsigned uci  = {63'd0, cin};
      longint          half = longint'(64'd1 << (w - 1));
      longint          sci  = longint'(uci);
      longint          sa;
      longint          sb;
      longint          rs;
      longint unsigned ru;
      res_t            r;
      sa = (longint'(ua) >= half) ? longint'(ua) - 2 * half : longint'(ua);
      sb = (longint'(ub) >= half) ? longint'(ub) - 2 * half : longint'(ub);
      if (!sub) begin
         ru     = ua + ub + uci;
         r.cout = (ru > m);
         rs     = sa + sb + sci;
      end else begin
         ru     = ua - ub - uci;
         r.cout = (ua >= ub + uci);
         rs     = sa - sb - sci;
      end
      r.sum  = 32'(ru & m);
      r.ovf  = (rs >= half) || (rs < -half);
      r.zero = ((ru & m) == 0);
      return r;
   endfunction

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W = cfg_w(g);
      localparam int S = cfg_s(g);

      logic         in_ready;
      logic         out_valid;
      logic         cout;
      logic         ovf;
      logic         zero;
      logic [W-1:0] sum;
      exp_e         q[$];
      int           n_out;
      bit           prev_stall;
      logic [W-1:0] prev_sum;
      logic         prev_c;
      logic         prev_o;
      logic         prev_z;

      pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (iv_d[g]),
         .in_ready (in_ready),
         .a        (a_d[g][W-1:0]),
         .b        (b_d[g][W-1:0]),
         .cin      (cin_d[g]),
         .sub      (sub_d[g]),
         .out_valid(out_valid),
         .out_ready(or_d[g]),
         .sum      (sum),
         .cout     (cout),
         .ovf      (ovf),
         .zero     (zero)
      );

      // Compare process: sees what the next rising edge will accept/consume.
      always @(negedge clk) begin : cmp
         exp_e e;
         if (rst) begin
            chk($sformatf("d%0d in_ready_during_rst", g), in_ready, 1);
            q.delete();
            prev_stall = 1'b0;
         end else begin
            chk($sformatf("d%0d in_ready_rule", g), in_ready, !(out_valid && !or_d[g]));
            if (prev_stall) begin
               chk($sformatf("d%0d stall_valid", g), out_valid, 1);
               chk($sformatf("d%0d stall_sum", g), sum, prev_sum);
               chk($sformatf("d%0d stall_flags", g), {cout, ovf, zero}, {prev_c, prev_o, prev_z});
            end
            if (out_valid && or_d[g]) begin
               chk($sformatf("d%0d beat_expected", g), q.size() > 0, 1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  chk($sformatf("d%0d sum", g), sum, e.r.sum);
                  chk($sformatf("d%0d cout", g), cout, e.r.cout);
                  chk($sformatf("d%0d ovf", g), ovf, e.r.ovf);
                  chk($sformatf("d%0d zero", g), zero, e.r.zero);
                  if (e.strict)
                     chk($sformatf("d%0d latency", g), cyc - e.t, S);
                  else
                     chk($sformatf("d%0d latency_min", g), (cyc - e.t) >= S, 1);
               end
               n_out++;
            end
            if (iv_d[g] && in_ready) begin
               e.r      = model(W, a_d[g], b_d[g], cin_d[g], sub_d[g]);
               e.t      = cyc;
               e.strict = strict_lat;
               q.push_back(e);
            end
            prev_stall = out_valid && !or_d[g];
            prev_sum   = sum;
            prev_c     = cout;
            prev_o     = ovf;
            prev_z     = zero;
         end
      end
   end

   // Single beat into the 32-bit instance with a literal expected result.
   task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic sub, input logic [31:0] es, input logic ec,
                           input logic eo, input logic ez);
      a_d[0]   = a;
      b_d[0]   = b;
      cin_d[0] = cin;
      sub_d[0] = sub;
      iv_d[0]  = 1'b1;
      @(posedge clk);
      #1;
      iv_d[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("dir out_valid", g_dut[0].out_valid, 1);
      chk("dir sum", g_dut[0].sum, es);
      chk("dir cout", g_dut[0].cout, ec);
      chk("dir ovf", g_dut[0].ovf, eo);
      chk("dir zero", g_dut[0].zero, ez);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cleared(input string nm);
      chk({nm, " out_valid"}, g_dut[0].out_valid, 0);
      chk({nm, " sum"}, g_dut[0].sum, 0);
      chk({nm, " flags"}, {g_dut[0].cout, g_dut[0].ovf, g_dut[0].zero}, 0);
   endtask

   initial begin
      res_t r;
      int   acc;
      int   budget;
      int   base;
      bit   took;
      logic xc;
      logic xs;
      checks     = 0;
      failures   = 0;
      cyc        = 0;
      rst        = 1'b1;
      strict_lat = 1'b1;
      for (int g = 0; g < NDUT; g++) begin
         iv_d[g]  = 1'b0;
         a_d[g]   = '0;
         b_d[g]   = '0;
         cin_d[g] = 1'b0;
         sub_d[g] = 1'b0;
         or_d[g]  = 1'b1;
      end

      // Hand-computed values pinning the model.
      r = model(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      chk("model wrap", r, {32'h0, 1'b1, 1'b0, 1'b1});
      r = model(32, 32'h5, 32'h7, 1'b0, 1'b1);
      chk("model sub neg", r, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      r = model(32, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
      chk("model sub ovf", r, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
      r = model(8, 32'h7F, 32'h1, 1'b0, 1'b0);
      chk("model8 add ovf", r, {32'h80, 1'b0, 1'b1, 1'b0});
      r = model(8, 32'h00, 32'h00, 1'b1, 1'b1);
      chk("model8 borrow", r, {32'hFF, 1'b0, 1'b0, 1'b0});

      repeat (2) @(posedge clk);
      #1;
      chk_cleared("reset");
      rst = 1'b0;

      directed(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      directed(32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      directed(32'h7, 32'h5, 1'b1, 1'b1, 32'h1, 1'b1, 1'b0, 1'b0);
      directed(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      directed(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

      // Back-to-back random beats against random backpressure.
      strict_lat = 1'b0;
      base       = g_dut[0].n_out;
      acc        = 0;
      budget     = 0;
      a_d[0]     = rnd_op();
      b_d[0]     = rnd_op();
      cin_d[0]   = 1'($urandom_range(0, 1));
      sub_d[0]   = 1'($urandom_range(0, 1));
      iv_d[0]    = 1'b1;
      or_d[0]    = 1'($urandom_range(0, 1));
      while (acc < 200 && budget < 5000) begin
         @(negedge clk);
         took = g_dut[0].in_ready;
         @(posedge clk);
         #1;
         budget++;
         if (took) begin
            acc++;
            a_d[0]   = rnd_op();
            b_d[0]   = rnd_op();
            cin_d[0] = 1'($urandom_range(0, 1));
            sub_d[0] = 1'($urandom_range(0, 1));
         end
         iv_d[0] = (acc < 200);
         or_d[0] = 1'($urandom_range(0, 1));
      end
      iv_d[0] = 1'b0;
      chk("bp accepted", acc, 200);
      or_d[0] = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("bp emitted", g_dut[0].n_out - base, 200);
      chk("bp drained", g_dut[0].q.size(), 0);

      // Reset with three beats in flight.
      strict_lat = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_d[0]   = rnd_op();
         b_d[0]   = rnd_op();
         cin_d[0] = 1'($urandom_range(0, 1));
         sub_d[0] = 1'($urandom_range(0, 1));
         iv_d[0]  = 1'b1;
         @(posedge clk);
         #1;
      end
      iv_d[0] = 1'b0;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      chk_cleared("midrst");
      chk("midrst in_ready", g_dut[0].in_ready, 1);
      rst  = 1'b0;
      base = g_dut[0].n_out;
      repeat (10) @(posedge clk);
      #1;
      chk("post-rst no stale", g_dut[0].n_out - base, 0);
      directed(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
      chk("post-rst one beat", g_dut[0].n_out - base, 1);

      // 8-bit instances: every a,b pair, random carry/mode, full throughput.
      for (int x = 0; x < 256; x++) begin
         for (int y = 0; y < 256; y++) begin
            xc = 1'($urandom_range(0, 1));
            xs = 1'($urandom_range(0, 1));
            for (int g = 1; g < NDUT; g++) begin
               a_d[g]   = 32'(x);
               b_d[g]   = 32'(y);
               cin_d[g] = xc;
               sub_d[g] = xs;
               iv_d[g]  = 1'b1;
            end
            @(posedge clk);
            #1;
         end
      end
      for (int g = 1; g < NDUT; g++) iv_d[g] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("w8s1 count", g_dut[1].n_out, 65536);
      chk("w8s2 count", g_dut[2].n_out, 65536);
      chk("w8s8 count", g_dut[3].n_out, 65536);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
